// File: rtl/seg_scan_driver_if.sv
// Controller <-> scan-driver bundle: raw segment pattern in, anode/cathode drive out.
// Latency: n/a (wires only).
// Backpressure: none; pat_load is a fire-and-forget strobe. Optional macro: SEG_SCROLL_EN adds scroll_en.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [7*NUM_DIGITS-1:0] pat_in;
  logic                    pat_load;
  logic                    blink_en;
`ifdef SEG_SCROLL_EN
  logic                    scroll_en;
`endif
  logic [NUM_DIGITS-1:0]   digit;
  logic [6:0]              seg;
  logic                    frame_done;

`ifdef SEG_SCROLL_EN
  modport master (output pat_in, pat_load, blink_en, scroll_en,
                  input  digit, seg, frame_done);
  modport slave  (input  pat_in, pat_load, blink_en, scroll_en,
                  output digit, seg, frame_done);
`else
  modport master (output pat_in, pat_load, blink_en,
                  input  digit, seg, frame_done);
  modport slave  (input  pat_in, pat_load, blink_en,
                  output digit, seg, frame_done);
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered pattern, blink and frame strobe.
// Latency: digit/seg update 1 clk after each slot tick; a load shows from digit 0 of the next frame.
// Backpressure: none; loads never stall, last load before a frame boundary wins. Optional macro: SEG_SCROLL_EN.
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int CLK_DIV       = 10000,
  parameter int BLINK_FRAMES  = 64,
  parameter int SCROLL_FRAMES = 128
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = 7 * NUM_DIGITS;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [PW-1:0] shadow;
  logic [PW-1:0] pending;
  logic          pend_vld;
  logic [BW-1:0] blink_cnt;
  logic          phase_off;

  logic          tick;
  logic          fb;
  logic          shadow_upd;
  logic [IW-1:0] idx_nxt;
  logic [PW-1:0] shadow_nxt;
  logic          phase_off_nxt;
  logic          blank;
  logic [IW-1:0] sel;

  // Slot/frame timing and the values the display will hold after this edge.
  // seg is looked up from the post-boundary shadow/phase so a new frame starts clean.
  always_comb begin
    tick          = (div == DIV_LAST);
    fb            = tick && (idx == IDX_LAST);
    idx_nxt       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    shadow_upd    = fb && (bus.pat_load || pend_vld);
    shadow_nxt    = shadow;
    if (fb) begin
      if (bus.pat_load)  shadow_nxt = bus.pat_in;
      else if (pend_vld) shadow_nxt = pending;
    end
    phase_off_nxt = phase_off;
    if (fb && (blink_cnt == BLINK_LAST)) phase_off_nxt = ~phase_off;
    blank         = bus.blink_en && phase_off_nxt;
  end

`ifdef SEG_SCROLL_EN
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_FRAMES - 1);
  localparam logic [IW:0]   NUM_W       = (IW+1)'(NUM_DIGITS);

  logic [IW-1:0] offset;
  logic [IW-1:0] offset_nxt;
  logic [SW-1:0] scroll_cnt;
  logic [IW:0]   sel_sum;

  // Scroll offset: restarts on every new pattern, steps once per SCROLL_FRAMES scrolled frames.
  always_comb begin
    offset_nxt = offset;
    if (shadow_upd)
      offset_nxt = '0;
    else if (fb && bus.scroll_en && (scroll_cnt == SCROLL_LAST))
      offset_nxt = (offset == IDX_LAST) ? '0 : offset + 1'b1;
    sel_sum = {1'b0, idx_nxt} + {1'b0, offset_nxt};
    sel     = (sel_sum >= NUM_W) ? IW'(sel_sum - NUM_W) : sel_sum[IW-1:0];
  end

  // Scroll frame counter and offset register.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset     <= '0;
      scroll_cnt <= '0;
    end else begin
      offset <= offset_nxt;
      if (shadow_upd)
        scroll_cnt <= '0;
      else if (fb && bus.scroll_en)
        scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + 1'b1;
    end
  end
`else
  // Without scrolling each slot shows its own shadow digit.
  always_comb sel = idx_nxt;
`endif

  // Prescaler, scan index, registered anode/cathode drive, buffers and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      idx        <= '0;
      bus.digit  <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      bus.seg    <= 7'h7F;
      bus.frame_done <= 1'b0;
      shadow     <= '1;
      pending    <= '1;
      pend_vld   <= 1'b0;
      blink_cnt  <= '0;
      phase_off  <= 1'b0;
    end else begin
      div            <= tick ? '0 : div + 1'b1;
      bus.frame_done <= fb;
      if (tick) begin
        idx       <= idx_nxt;
        bus.digit <= ~(NUM_DIGITS'(1) << idx_nxt);
        bus.seg   <= blank ? 7'h7F : shadow_nxt[7*sel +: 7];
      end
      shadow <= shadow_nxt;
      if (bus.pat_load) pending <= bus.pat_in;
      if (fb)                pend_vld <= 1'b0;
      else if (bus.pat_load) pend_vld <= 1'b1;
      if (fb) begin
        blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        phase_off <= phase_off_nxt;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4 clk/slot, 2-frame blink, 1-frame scroll).
// Reference model derives slot/frame/blink phase arithmetically from cycles since reset.
// Scroll checks are built only when SEG_SCROLL_EN is defined.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int N = 4, CD = 4, BF = 2, SF = 1, FRAME = CD * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(N)) bus();

  seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLINK_FRAMES(BF), .SCROLL_FRAMES(SF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [27:0]          pat;
    logic [0:3][6:0]      exp_seg;   // expected cathodes for slot 0..3
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          k = 0;              // clock edges since reset released
  logic [27:0] m_shadow = '1;
  logic [27:0] m_pend = '1;
  bit          m_pvld = 0;
  int          m_off = 0;
  int          m_sfr = 0;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_fd = 1'b0;
  logic [3:0]  m_digit = 4'hE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic bit scroll_in();
`ifdef SEG_SCROLL_EN
    return bus.scroll_en;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural reference: frame and slot come straight from the edge count.
  task automatic model_step();
    bit tk, fb, upd;
    int slot, fr;
    if (rst) begin
      k = 0; m_shadow = '1; m_pvld = 0; m_off = 0; m_sfr = 0; m_seg = 7'h7F; m_fd = 1'b0;
    end else begin
      k++;
      tk = (k % CD) == 0;
      fb = (k % FRAME) == 0;
      m_fd = fb;
      if (fb) begin
        upd = bus.pat_load || m_pvld;
        if (bus.pat_load) m_shadow = bus.pat_in;
        else if (m_pvld)  m_shadow = m_pend;
        m_pvld = 0;
        if (upd) begin
          m_off = 0; m_sfr = 0;
        end else if (scroll_in()) begin
          m_sfr++;
          if (m_sfr == SF) begin m_sfr = 0; m_off = (m_off + 1) % N; end
        end
      end else if (bus.pat_load) begin
        m_pend = bus.pat_in; m_pvld = 1;
      end
      if (tk) begin
        slot = (k / CD) % N;
        fr   = k / FRAME;
        m_seg = (bus.blink_en && ((fr / BF) % 2 == 1)) ? 7'h7F : m_shadow[7*((slot + m_off) % N) +: 7];
      end
    end
    m_digit = ~(4'b0001 << ((k / CD) % N));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("digit", {28'd0, bus.digit}, {28'd0, m_digit});
    check("seg", {25'd0, bus.seg}, {25'd0, m_seg});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, m_fd});
  endtask

  // Advance until the frame phase equals ph (always at least one edge).
  task automatic run_until(input int ph);
    int n;
    n = 0;
    do begin cyc(); n++; end while (((k % FRAME) != ph) && (n < 4 * FRAME));
    if ((k % FRAME) != ph) begin
      n_chk++; n_fail++;
      $display("FAIL run_until: phase %0d expected %0d", k % FRAME, ph);
    end
  endtask

  task automatic load_at(input int ph, input logic [27:0] p);
    run_until(ph);
    bus.pat_in = p; bus.pat_load = 1'b1;
    cyc();
    bus.pat_load = 1'b0;
  endtask

  initial begin
    vec_t        vecs[4];
    int          fd_cnt;
    bit          bl[4];
    bit          found;
    logic [27:0] P;
    vecs[0] = '{pat: {7'h40, 7'h79, 7'h24, 7'h30}, exp_seg: {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[1] = '{pat: {7'h7F, 7'h00, 7'h7F, 7'h00}, exp_seg: {7'h00, 7'h7F, 7'h00, 7'h7F}};
    vecs[2] = '{pat: {7'h12, 7'h02, 7'h78, 7'h00}, exp_seg: {7'h00, 7'h78, 7'h02, 7'h12}};
    vecs[3] = '{pat: {7'h3F, 7'h06, 7'h5B, 7'h4F}, exp_seg: {7'h4F, 7'h5B, 7'h06, 7'h3F}};
    P = {7'h40, 7'h79, 7'h24, 7'h30};

    bus.pat_in = '0; bus.pat_load = 1'b0; bus.blink_en = 1'b0;
`ifdef SEG_SCROLL_EN
    bus.scroll_en = 1'b0;
`endif

    // Reset values
    rst = 1'b1;
    cyc(); cyc();
    check("reset_digit", {28'd0, bus.digit}, 32'hE);
    check("reset_seg", {25'd0, bus.seg}, 32'h7F);
    check("reset_frame_done", {31'd0, bus.frame_done}, 32'h0);
    rst = 1'b0;

    // Blank scan of one full frame
    fd_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (bus.frame_done) fd_cnt++;
      if (i == 4)  check("scan_d1", {28'd0, bus.digit}, 32'hD);
      if (i == 8)  check("scan_d2", {28'd0, bus.digit}, 32'hB);
      if (i == 12) check("scan_d3", {28'd0, bus.digit}, 32'h7);
      if (i == 16) check("scan_wrap", {28'd0, bus.digit}, 32'hE);
    end
    check("frame_done_count", fd_cnt, 1);

    // Table: mid-frame load, visible from the next frame, slot by slot
    for (int i = 0; i < 4; i++) begin
      load_at(6, vecs[i].pat);
      run_until(0);
      check($sformatf("vec%0d_slot0", i), {25'd0, bus.seg}, {25'd0, vecs[i].exp_seg[0]});
      for (int j = 1; j < 4; j++) begin
        run_until(4 * j);
        check($sformatf("vec%0d_slot%0d", i, j), {25'd0, bus.seg}, {25'd0, vecs[i].exp_seg[j]});
      end
    end

    // Two loads in one frame (last wins), then a load coincident with the boundary
    load_at(4, {7'h01, 7'h02, 7'h03, 7'h04});
    load_at(8, {7'h11, 7'h22, 7'h33, 7'h44});
    run_until(0);
    check("last_load_wins", {25'd0, bus.seg}, 32'h44);
    load_at(15, {7'h55, 7'h66, 7'h0F, 7'h1E});
    check("fb_load_direct", {25'd0, bus.seg}, 32'h1E);
    run_until(0);
    check("fb_load_no_pending", {25'd0, bus.seg}, 32'h1E);

    // Blink: two lit frames, two blank frames, scanning continues
    load_at(3, P);
    run_until(0);
    bus.blink_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_until(0);
      bl[f] = (bus.seg == 7'h7F);
    end
    check("blink_pair_a", {31'd0, bl[1]}, {31'd0, bl[0]});
    check("blink_pair_b", {31'd0, bl[3]}, {31'd0, bl[2]});
    check("blink_alternate", {31'd0, bl[2]}, {31'd0, !bl[0]});
    found = 0;
    for (int f = 0; f < 4 && !found; f++) begin
      run_until(0);
      if (bus.seg == 7'h7F) found = 1;
    end
    check("blank_frame_found", {31'd0, found}, 32'h1);
    run_until(5);
    bus.blink_en = 1'b0;
    run_until(8);
    check("unblink_next_tick", {25'd0, bus.seg}, 32'h79);

    // Reset mid-frame discards a pending load
    load_at(6, 28'h0);
    run_until(9);
    rst = 1'b1;
    cyc();
    check("midrst_digit", {28'd0, bus.digit}, 32'hE);
    check("midrst_seg", {25'd0, bus.seg}, 32'h7F);
    check("midrst_frame_done", {31'd0, bus.frame_done}, 32'h0);
    rst = 1'b0;
    run_until(0);
    check("pending_discarded_s0", {25'd0, bus.seg}, 32'h7F);
    run_until(4);
    check("pending_discarded_s1", {25'd0, bus.seg}, 32'h7F);

`ifdef SEG_SCROLL_EN
    // Scroll: slot 0 walks through the digits, a new load restarts it
    begin
      logic [6:0] sexp [4];
      sexp[0] = 7'h24; sexp[1] = 7'h79; sexp[2] = 7'h40; sexp[3] = 7'h30;
      load_at(3, P);
      run_until(0);
      check("scroll_start", {25'd0, bus.seg}, 32'h30);
      bus.scroll_en = 1'b1;
      for (int f = 0; f < 4; f++) begin
        run_until(0);
        check($sformatf("scroll_f%0d", f), {25'd0, bus.seg}, {25'd0, sexp[f]});
      end
      run_until(0);
      load_at(3, P);
      run_until(0);
      check("scroll_reload", {25'd0, bus.seg}, 32'h30);
      bus.scroll_en = 1'b0;
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.pat_load = ($urandom_range(0, 7) == 0);
      bus.pat_in   = 28'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blink_en = ~bus.blink_en;
`ifdef SEG_SCROLL_EN
      if ($urandom_range(0, 15) == 0) bus.scroll_en = ~bus.scroll_en;
`endif
      rst = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0; bus.pat_load = 1'b0; bus.blink_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
